// File: rtl/mem_access_stage.sv
// mem_access_stage -- memory-access stage of the pipelined CPU.
//
// Converts the load/store in MEM into a registered req/ack transaction on
// the data bus. Handles byte/half/word lanes (little-endian), sub-word load
// extension, alignment exceptions and pipeline stall generation.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a REQ that sees no dbus_ack for TIMEOUT_CYCLES cycles is
//               aborted and mem_bus_err pulses for the DONE cycle.
//   undefined : REQ waits for dbus_ack indefinitely, mem_bus_err = 0.
//
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   mem_wreg/m2reg/wmem      control from EXE/MEM
//   mem_rn                   destination register (not used in this stage)
//   mem_alu, mem_b           effective address, store data
//   mem_size, mem_sext       access size (00 B, 01 H, 1x W), sign-extend
//   dbus_*                   data bus (req/we/addr/wdata/be out, ack/rdata in)
//   mem_mo, mem_wreg_q       load result / qualified write-enable to MEM/WB
//   mem_stall                pipeline freeze while the bus is busy
//   mem_misalign             alignment exception
//   mem_bus_err              bus timeout exception
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic        mem_wmem,
  input  logic [4:0]  mem_rn,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_b,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] mem_mo,
  output logic        mem_wreg_q,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        access, misal, is_byte, is_half;
  logic [1:0]  off;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic        tmo_fire;
  logic        bus_err_q;

  // mem_rn is carried by the pipeline register, not by this stage
  logic unused_ok;
  assign unused_ok = ^mem_rn;

  assign access  = mem_m2reg | mem_wmem;
  assign off     = mem_alu[1:0];
  assign is_byte = (mem_size == 2'b00);
  assign is_half = (mem_size == 2'b01);
  assign misal   = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = mem_b;
    if (is_byte) begin
      be_n    = 4'b0001 << off;
      wdata_n = {4{mem_b[7:0]}};
    end else if (is_half) begin
      be_n    = 4'b0011 << off;
      wdata_n = {2{mem_b[15:0]}};
    end
  end

  // Read lane: the MEM instruction is frozen until DONE, so the current
  // size/offset/sext inputs still describe the captured word.
  assign lane = rdata_q >> {off, 3'b000};
  always_comb begin
    load_ext = rdata_q;
    if (is_byte)
      load_ext = {{24{mem_sext & lane[7]}}, lane[7:0]};
    else if (is_half)
      load_ext = {{16{mem_sext & lane[15]}}, lane[15:0]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_be    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (access && !misal) begin
          state      <= REQ;
          dbus_req   <= 1'b1;
          dbus_we    <= mem_wmem;
          dbus_addr  <= {mem_alu[31:2], 2'b00};
          dbus_wdata <= wdata_n;
          dbus_be    <= be_n;
        end
        REQ: begin
          // ack is tested first so a same-edge ack beats the timeout
          if (dbus_ack) begin
            if (mem_m2reg) rdata_q <= dbus_rdata;
            dbus_req <= 1'b0;
            state    <= DONE;
          end else if (tmo_fire) begin
            dbus_req <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  assign tmo_fire = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counter is zero on REQ entry; the flag is set on the abort edge and
  // therefore covers exactly the DONE cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= (state == REQ) & ~dbus_ack & tmo_fire;
      if (state != REQ) tmo_cnt <= '0;
      else if (!dbus_ack) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_fire   = 1'b0;
  assign bus_err_q  = 1'b0;
`endif

  assign mem_bus_err  = bus_err_q;
  assign mem_misalign = access & misal;
  assign mem_stall    = access & ~misal & (state != DONE);
  assign mem_mo       = (state == DONE && mem_m2reg && !bus_err_q) ? load_ext : 32'd0;

  always_comb begin
    if (!access)     mem_wreg_q = mem_wreg;
    else if (misal)  mem_wreg_q = 1'b0;
    else             mem_wreg_q = (state == DONE) & mem_wreg & ~bus_err_q;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TMO = 4;

  logic        clk = 0, clr = 1;
  logic        mem_wreg = 0, mem_m2reg = 0, mem_wmem = 0, mem_sext = 0;
  logic [4:0]  mem_rn = 0;
  logic [31:0] mem_alu = 0, mem_b = 0, dbus_rdata = 0;
  logic [1:0]  mem_size = 0;
  logic        dbus_ack = 0;
  logic        dbus_req, dbus_we, mem_wreg_q, mem_stall, mem_misalign, mem_bus_err;
  logic [31:0] dbus_addr, dbus_wdata, mem_mo;
  logic [3:0]  dbus_be;

  int checks = 0, failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_wmem(mem_wmem), .mem_rn(mem_rn), .mem_alu(mem_alu), .mem_b(mem_b),
    .mem_size(mem_size), .mem_sext(mem_sext), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_mo(mem_mo), .mem_wreg_q(mem_wreg_q), .mem_stall(mem_stall),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the access rules ----
  function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] a);
    int o = int'(a[1:0]);
    if (sz == 2'd0) return 0;
    if (sz == 2'd1) return (o % 2) != 0;
    return o != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int o = int'(a[1:0]);
    if (sz == 2'd0) return 4'(1 * (2 ** o));
    if (sz == 2'd1) return 4'(3 * (2 ** o));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] b);
    if (sz == 2'd0) return (b % 256) * 32'h01010101;
    if (sz == 2'd1) return (b % 65536) * 32'h00010001;
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd, input bit sx);
    logic [31:0] v = rd / (32'd1 << (8 * int'(a[1:0])));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end else v = rd;
    return v;
  endfunction

  task automatic set_idle();
    mem_m2reg = 0; mem_wmem = 0; mem_wreg = 1'($urandom); mem_rn = 5'($urandom);
    mem_alu = $urandom; mem_size = 2'($urandom);
  endtask

  // One MEM instruction. d = REQ cycles before ack (0 = ack in first REQ
  // cycle); d < 0 = never ack, a bus timeout is expected.
  task automatic do_txn(input bit ld, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rd, input bit sx,
                        input bit wr, input int d);
    int stall_cnt = 0, req_cnt = 0;
    bit done = 0;
    @(negedge clk);
    mem_m2reg = ld; mem_wmem = !ld; mem_size = sz; mem_alu = a; mem_b = b;
    mem_sext = sx; mem_wreg = wr; mem_rn = 5'($urandom); dbus_rdata = rd; dbus_ack = 0;
    #1;
    if (m_misal(sz, a)) begin
      chk("misal_flag", 32'(mem_misalign), 1);
      chk("misal_stall", 32'(mem_stall), 0);
      chk("misal_wreg", 32'(mem_wreg_q), 0);
      @(negedge clk); #1;
      chk("misal_noreq", 32'(dbus_req), 0);
      set_idle();
      return;
    end
    chk("misal_clear", 32'(mem_misalign), 0);
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (!mem_stall) done = 1;
      else stall_cnt++;
      if (dbus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk("bus_addr", dbus_addr, {a[31:2], 2'b00});
          chk("bus_be", 32'(dbus_be), 32'(m_be(sz, a)));
          chk("bus_we", 32'(dbus_we), 32'(!ld));
          if (!ld) chk("bus_wdata", dbus_wdata, m_wdata(sz, b));
        end
        dbus_ack = (d >= 0 && req_cnt == d + 1);
      end else dbus_ack = 0;
    end
    dbus_ack = 0;
    if (!done) begin
      chk("stall_bound", 0, 1);
      return;
    end
    chk("done_req", 32'(dbus_req), 0);
    if (d >= 0) begin
      chk("stall_cycles", stall_cnt, d + 2);
      chk("done_mo", mem_mo, ld ? m_load(sz, a, rd, sx) : 32'd0);
      chk("done_wreg", 32'(mem_wreg_q), 32'(wr));
      chk("done_err", 32'(mem_bus_err), 0);
    end else begin
      chk("tmo_req_cycles", req_cnt, TMO);
      chk("tmo_err", 32'(mem_bus_err), 1);
      chk("tmo_wreg", 32'(mem_wreg_q), 0);
      chk("tmo_mo", mem_mo, 0);
    end
    @(negedge clk);
    set_idle();
    #1;
    chk("after_err", 32'(mem_bus_err), 0);
  endtask

  initial begin
    #3;
    chk("rst_req", 32'(dbus_req), 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_be", 32'(dbus_be), 0);
    chk("rst_mo", mem_mo, 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_err", 32'(mem_bus_err), 0);
    @(negedge clk); clr = 0;

    // no access: pass-through, spurious ack ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle(); dbus_ack = 1; dbus_rdata = $urandom;
      #1;
      chk("idle_wreg", 32'(mem_wreg_q), 32'(mem_wreg));
      chk("idle_mo", mem_mo, 0);
      chk("idle_stall", 32'(mem_stall), 0);
      chk("idle_misal", 32'(mem_misalign), 0);
      chk("idle_req", 32'(dbus_req), 0);
    end
    @(negedge clk); dbus_ack = 0;

    // directed cases
    do_txn(1, 2'd2, 32'h100, 0, 32'h8899AABB, 0, 1, 0);
    do_txn(1, 2'd0, 32'h103, 0, 32'h80112233, 1, 1, 0);
    do_txn(1, 2'd0, 32'h103, 0, 32'h80112233, 0, 1, 1);
    do_txn(0, 2'd1, 32'h102, 32'h1234ABCD, 0, 0, 0, 2);
    do_txn(1, 2'd2, 32'h101, 0, 0, 0, 1, 0);
    do_txn(1, 2'd3, 32'h204, 0, 32'hCAFEF00D, 1, 1, 0);

    // reset while in REQ, late ack ignored
    @(negedge clk);
    mem_m2reg = 1; mem_wmem = 0; mem_size = 2'd2; mem_alu = 32'h300; mem_wreg = 1;
    @(negedge clk); #1;
    chk("pre_rst_req", 32'(dbus_req), 1);
    clr = 1; #1;
    chk("rst_async_req", 32'(dbus_req), 0);
    set_idle(); #1; clr = 0;
    @(negedge clk); dbus_ack = 1; dbus_rdata = 32'hDEADBEEF; #1;
    chk("late_ack_req", 32'(dbus_req), 0);
    @(negedge clk); dbus_ack = 0; #1;
    chk("late_ack_req2", 32'(dbus_req), 0);
    chk("late_ack_mo", mem_mo, 0);
    chk("late_ack_stall", 32'(mem_stall), 0);

`ifdef MEM_TIMEOUT_EN
    do_txn(1, 2'd2, 32'h400, 0, 32'h11111111, 0, 1, -1);
    do_txn(1, 2'd2, 32'h404, 0, 32'h22222222, 0, 1, TMO - 1);
`endif

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = $urandom;
      do_txn(1'($urandom), 2'($urandom), a, $urandom, $urandom, 1'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the interrupt-capable pipelined CPU.
- Sits between the EXE/MEM pipeline register and the MEM/WB register.
- Turns the load/store request in MEM into a req/ack transaction on the data bus and handles byte, halfword and word lanes.
- Produces the loaded word (mem_mo) and the qualified write-enable for MEM/WB, and stalls the pipeline while the bus is busy.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for dbus_ack before aborting. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- clr  in  1  asynchronous, active-high reset
- mem_wreg  in  1  register write-enable from EXE/MEM
- mem_m2reg  in  1  load: result comes from memory
- mem_wmem  in  1  store
- mem_rn  in  5  destination register; passed through unchanged
- mem_alu  in  32  effective address
- mem_b  in  32  store data
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
- mem_sext  in  1  sign-extend sub-word loads
- dbus_req  out  1  bus request; registered
- dbus_we  out  1  write strobe; registered
- dbus_addr  out  32  word address: mem_alu with [1:0] forced to 00; registered
- dbus_wdata  out  32  store data replicated across lanes; registered
- dbus_be  out  4  byte enables; registered
- dbus_ack  in  1  one-cycle completion pulse
- dbus_rdata  in  32  read data, valid when dbus_ack=1
- mem_mo  out  32  extended load result to MEM/WB
- mem_wreg_q  out  1  qualified write-enable to MEM/WB
- mem_stall  out  1  freezes the upstream pipeline and the MEM/WB load
- mem_misalign  out  1  alignment exception, routed to the interrupt/cause logic
- mem_bus_err  out  1  bus timeout exception (MEM_TIMEOUT_EN only)

Behaviour:
- access = mem_m2reg | mem_wmem.
- Misaligned means:
  - half access with mem_alu[0]=1, or
  - word access with mem_alu[1:0]≠00.
- Reset (clr=1, asynchronous):
  - state=IDLE; dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be all 0.
  - Captured-data register = 0; mem_mo=0, mem_stall=0, mem_misalign=0, mem_bus_err=0.
  - A transaction in flight is abandoned: req drops immediately and no retry occurs after reset.
- States: IDLE, REQ, DONE.
- IDLE:
  - access and aligned: next state REQ. Load dbus_addr/we/be/wdata. dbus_req=1 from the next cycle.
  - Misaligned: no request is issued. mem_misalign=1 combinationally while the instruction sits in MEM. mem_wreg_q=0 and no stall.
  - No access: mem_wreg_q=mem_wreg, mem_mo=0, no stall.
- REQ:
  - Hold dbus_req and all bus outputs stable until dbus_ack.
  - On ack: capture dbus_rdata (loads only), drop dbus_req the same edge, go to DONE.
- DONE:
  - mem_stall=0 for exactly one cycle; mem_mo is driven from the captured data.
  - Next state IDLE. The next access cannot start before the following cycle.
- Stall rule: mem_stall = access & aligned & (state≠DONE), combinational. Minimum load/store latency is 3 cycles (IDLE, REQ with immediate ack, DONE).
- dbus_ack while dbus_req=0 is ignored.
- Byte lanes (little-endian), selected by mem_alu[1:0]:
  - Byte: be=0001<<a[1:0]; wdata={4{b[7:0]}}.
  - Half: be=0011<<a[1:0]; wdata={2{b[15:0]}}.
  - Word: be=1111.
  - Read lane uses the same offsets.
- Load extension: byte/half results are zero-extended, or sign-extended when mem_sext=1. Word results are passed unchanged.
- Stores drive mem_mo=0 and mem_wreg_q=mem_wreg.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop req, go to DONE, and pulse mem_bus_err for the DONE cycle.
  - mem_wreg_q=0 in that cycle and mem_mo=0.
  - An ack arriving on the same edge as the timeout wins: normal completion, no error.
- Undefined: REQ waits indefinitely; mem_bus_err is tied 0 and the counter is absent.

Test Plan:
- Word load, addr 0x100, ack one cycle after req, rdata=0x8899AABB -> stall high 2 cycles; then mem_mo=0x8899AABB and mem_wreg_q=1 for one cycle.
- Signed byte load, addr 0x103, rdata=0x80112233 -> mem_mo=0xFFFFFF80; same with mem_sext=0 -> 0x00000080.
- Half store, addr 0x102, mem_b=0x1234ABCD -> dbus_be=1100, dbus_wdata=0xABCDABCD, dbus_we=1, dbus_addr=0x100.
- Word load at 0x101 -> no dbus_req; mem_misalign=1, mem_wreg_q=0, mem_stall=0.
- clr pulsed while in REQ with ack pending -> dbus_req=0 the same cycle, state IDLE; a late ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> req held 4 cycles, then mem_bus_err=1 for one cycle and mem_wreg_q=0.
